dfconv_job_scheduler: RTL
=========================

// Module: dfconv_job_scheduler
// PURPOSE
//  Shares one dfconv engine among NUM_REQ requesters. Each requester submits a
//  job descriptor (rows, cols, in_ch, out_ch) over valid/ready. Winners are picked
//  round-robin and the job is issued to dfconv (start pulse, descriptor held stable).
//  The scheduler waits for done, then returns a completion (requester id, cycles_used,
//  error flag) and keeps job/cycle statistics for the top-level performance model.
// PARAMETERS
//  NUM_REQ        4      number of requesters (2..8)
//  WIDTH          16     width of each descriptor field
//  ACC_WIDTH      32     width of cycle counts and statistics
//  TIMEOUT_CYCLES 65535  WAIT cycles before a job is aborted as timed out
// PORTS
//  clk         in   1                clock, all logic on rising edge
//  rst         in   1                synchronous reset, active-high
//  req_valid   in   NUM_REQ          per-requester job valid
//  req_ready   out  NUM_REQ          per-requester accept, at most one bit set
//  req_rows    in   NUM_REQ*WIDTH    rows, requester i at [i*WIDTH +: WIDTH]; same packing for cols/in_ch/out_ch
//  req_cols    in   NUM_REQ*WIDTH    cols
//  req_in_ch   in   NUM_REQ*WIDTH    input channels
//  req_out_ch  in   NUM_REQ*WIDTH    output channels
//  df_start    out  1                one-cycle start pulse to dfconv
//  df_rows, df_cols, df_in_ch, df_out_ch  out  WIDTH each  latched descriptor to dfconv
//  df_done     in   1                dfconv completion pulse
//  df_cycles   in   ACC_WIDTH        dfconv cycles_used, valid with df_done
//  cpl_valid   out  1                completion valid
//  cpl_ready   in   1                completion accept
//  cpl_id      out  $clog2(NUM_REQ)  requester index of the completed job
//  cpl_cycles  out  ACC_WIDTH        engine cycles for the job
//  cpl_err     out  1                1 = job timed out
//  busy        out  1                state != IDLE
//  stat_jobs   out  ACC_WIDTH        completions accepted, saturating
//  stat_cycles out  ACC_WIDTH        sum of accepted cpl_cycles, saturating
// BEHAVIOUR
//  Reset: state=IDLE. req_ready=0, df_start=0, df_* fields=0, cpl_valid=0, cpl_id=0,
//   cpl_cycles=0, cpl_err=0, busy=0, stat_*=0. rr_ptr=0, so requester 0 has the
//   highest priority first. Reset mid-job abandons the job with no completion.
//  IDLE: grant g = first i with req_valid[i] set, searching from rr_ptr upward with wrap.
//   req_ready[g]=1 is combinational, only in IDLE. On the handshake, latch g and the
//   descriptor. Go to ZCHK.
//  ZCHK: if any field is 0, set cpl_cycles=0, cpl_err=0 and go to REPORT; the engine is
//   not started. Otherwise go to ISSUE.
//  ISSUE: df_start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
//  WAIT: df_* fields stay stable from ISSUE until REPORT exits.
//   - On df_done: cpl_cycles<=df_cycles, cpl_err<=0, go to REPORT.
//   - If the counter reaches TIMEOUT_CYCLES: cpl_cycles<=TIMEOUT_CYCLES, cpl_err<=1,
//     go to REPORT.
//   - If df_done and timeout occur in the same cycle, df_done wins.
//   - df_done outside WAIT is ignored.
//  REPORT: cpl_valid=1 and completion fields held until cpl_ready. On accept:
//   stat_jobs+1, stat_cycles+cpl_cycles (both clamp at all-ones), rr_ptr<=(g+1)%NUM_REQ,
//   cpl_valid<=0, go to IDLE.
//  Timing: next grant no earlier than the cycle after the accept, so jobs never overlap.
//   Request to df_start latency is 2 cycles (handshake edge, ZCHK, ISSUE).
//  A requester dropping req_valid before its grant loses its turn silently.
// TESTING
//  1. Single job, req0 {4,4,36,36}; model dfconv returns done after 761 cycles ->
//     exactly one df_start, df_* stable through WAIT, cpl_id=0, cpl_cycles=761, cpl_err=0.
//  2. All 4 requesters valid at once with {8,8,36,36}, cycles 3044 -> grants in order
//     0,1,2,3; stat_jobs=4, stat_cycles=12176.
//  3. req2 job {0,4,36,36} -> no df_start; completion cpl_id=2, cpl_cycles=0, cpl_err=0.
//  4. TIMEOUT_CYCLES=20, model never asserts done -> cpl_err=1, cpl_cycles=20; the next
//     job issues normally.
//  5. Hold cpl_ready=0 for 10 cycles, then raise it -> cpl fields stable the whole time,
//     no new grant, stats update once.
//  6. Assert rst in WAIT, then submit {1,1,1,1} with done after 3 cycles -> all outputs
//     return to reset values; completion cpl_cycles=3, stat_jobs=1.

Source files
------------

// File: rtl/dfconv_job_scheduler.sv
// Round-robin scheduler sharing one dfconv engine among NUM_REQ requesters.
// Issues one job at a time, waits for done or timeout, reports a completion and keeps statistics.
//
// state  | meaning
// IDLE   | arbitrating, req_ready asserted toward the round-robin winner
// ZCHK   | descriptor latched, check for empty (zero-field) job
// ISSUE  | df_start pulse, timeout timer loaded
// WAIT   | engine running, waiting for df_done or timer terminal count
// REPORT | completion presented until cpl_ready
module dfconv_job_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 16,
    parameter int ACC_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_rows,
    input  logic [NUM_REQ*WIDTH-1:0]   req_cols,
    input  logic [NUM_REQ*WIDTH-1:0]   req_in_ch,
    input  logic [NUM_REQ*WIDTH-1:0]   req_out_ch,
    output logic                       df_start,
    output logic [WIDTH-1:0]           df_rows,
    output logic [WIDTH-1:0]           df_cols,
    output logic [WIDTH-1:0]           df_in_ch,
    output logic [WIDTH-1:0]           df_out_ch,
    input  logic                       df_done,
    input  logic [ACC_WIDTH-1:0]       df_cycles,
    output logic                       cpl_valid,
    input  logic                       cpl_ready,
    output logic [$clog2(NUM_REQ)-1:0] cpl_id,
    output logic [ACC_WIDTH-1:0]       cpl_cycles,
    output logic                       cpl_err,
    output logic                       busy,
    output logic [ACC_WIDTH-1:0]       stat_jobs,
    output logic [ACC_WIDTH-1:0]       stat_cycles
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [ACC_WIDTH-1:0] TMO = ACC_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZCHK,
        S_ISSUE,
        S_WAIT,
        S_REPORT
    } state_t;

    state_t               state, state_n;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       grant_id;
    logic                 grant_vld;
    logic [ACC_WIDTH-1:0] tmr;
    logic                 tmr_tc;
    logic                 fields_zero;
    logic                 accept;
    logic [ACC_WIDTH:0]   cyc_sum;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int j;
        j         = 0;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!grant_vld && req_valid[j]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(j);
            end
        end
    end

    assign fields_zero = (df_rows == '0) || (df_cols == '0) ||
                         (df_in_ch == '0) || (df_out_ch == '0);
    assign tmr_tc      = (tmr <= ACC_WIDTH'(1));
    assign cpl_valid   = (state == S_REPORT);
    assign busy        = (state != S_IDLE);
    assign accept      = cpl_valid && cpl_ready;
    assign cyc_sum     = {1'b0, stat_cycles} + {1'b0, cpl_cycles};

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        req_ready = '0;
        df_start  = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_vld && !rst) begin
                    req_ready[grant_id] = 1'b1;
                    state_n             = S_ZCHK;
                end
            end
            S_ZCHK:   state_n = fields_zero ? S_REPORT : S_ISSUE;
            S_ISSUE: begin
                df_start = 1'b1;
                state_n  = S_WAIT;
            end
            S_WAIT: begin
                if (df_done || tmr_tc) state_n = S_REPORT;
            end
            S_REPORT: begin
                if (cpl_ready) state_n = S_IDLE;
            end
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            cpl_id      <= '0;
            df_rows     <= '0;
            df_cols     <= '0;
            df_in_ch    <= '0;
            df_out_ch   <= '0;
            cpl_cycles  <= '0;
            cpl_err     <= 1'b0;
            tmr         <= '0;
            stat_jobs   <= '0;
            stat_cycles <= '0;
        end else begin
            if (state == S_IDLE && grant_vld) begin
                cpl_id    <= grant_id;
                df_rows   <= req_rows[int'(grant_id)*WIDTH +: WIDTH];
                df_cols   <= req_cols[int'(grant_id)*WIDTH +: WIDTH];
                df_in_ch  <= req_in_ch[int'(grant_id)*WIDTH +: WIDTH];
                df_out_ch <= req_out_ch[int'(grant_id)*WIDTH +: WIDTH];
            end
            if (state == S_ZCHK && fields_zero) begin
                cpl_cycles <= '0;
                cpl_err    <= 1'b0;
            end
            if (state == S_ISSUE) tmr <= TMO;
            // A done arriving on the terminal-count cycle takes priority.
            if (state == S_WAIT) begin
                if (df_done) begin
                    cpl_cycles <= df_cycles;
                    cpl_err    <= 1'b0;
                end else if (tmr_tc) begin
                    cpl_cycles <= TMO;
                    cpl_err    <= 1'b1;
                end else begin
                    tmr <= tmr - ACC_WIDTH'(1);
                end
            end
            if (accept) begin
                if (stat_jobs != '1) stat_jobs <= stat_jobs + ACC_WIDTH'(1);
                stat_cycles <= cyc_sum[ACC_WIDTH] ? '1 : cyc_sum[ACC_WIDTH-1:0];
                rr_ptr      <= (cpl_id == IDW'(NUM_REQ-1)) ? '0 : cpl_id + IDW'(1);
            end
        end
    end

endmodule
